// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux among eight requesters.
// Grants are bounded to MAX_HOLD transfers per tenure.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] w,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       f,
  output logic       f_valid,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    gnt_d;
  logic [2:0]    s_d;
  logic          f_d;
  logic          fv_d;

  logic [2:0]    nxt;
  logic          have_req;
  logic          xfer;
  logic          at_max;
  logic          rel;

  // Scan ptr+8 down to ptr+1 so the nearest requester after ptr wins.
  function automatic logic [2:0] pick(
    input logic [2:0] p,
    input logic [7:0] r
  );
    logic [2:0] idx;
    pick = p;
    for (int k = 8; k >= 1; k--) begin
      idx = p + 3'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign nxt      = pick(ptr_q, req);
  assign have_req = en && (|req);
  assign xfer     = req[s];
  assign at_max   = (cnt_q == CW'(MAX_HOLD));
  assign rel      = !xfer || at_max || !en;
  assign busy     = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt;
    s_d     = s;
    f_d     = f;
    fv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = 8'h00;
        if (have_req) begin
          state_d = GRANT;
          gnt_d   = 8'h01 << nxt;
          s_d     = nxt;
          ptr_d   = nxt;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        fv_d = xfer;
        if (xfer) f_d = w[s];
        if (rel) begin
          if (have_req) begin
            gnt_d = 8'h01 << nxt;
            s_d   = nxt;
            ptr_d = nxt;
            cnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      cnt_q   <= '0;
      gnt     <= 8'h00;
      s       <= 3'd0;
      f       <= 1'b0;
      f_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      s       <= s_d;
      f       <= f_d;
      f_valid <= fv_d;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed bench for mux8_rr_arbiter.
// A tenure-level reference model predicts every output each cycle.
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] req;
  logic [7:0] w;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       f;
  logic       f_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // reference model: who owns the mux, how many transfers so far
  int owner;
  int last;
  int done_xfers;
  bit m_f;
  bit m_fv;
  int m_s;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(3)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .w(w),
    .gnt(gnt), .s(s), .f(f), .f_valid(f_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int next_owner(input int after, input logic [7:0] r);
    for (int k = 1; k <= 8; k++)
      if (r[(after + k) % 8]) return (after + k) % 8;
    return -1;
  endfunction

  function automatic logic [14:0] expect_vec();
    logic [7:0] g;
    g = (owner >= 0) ? (8'h01 << owner) : 8'h00;
    return {g, 3'(m_s), m_f, m_fv, (owner >= 0)};
  endfunction

  task automatic model_edge();
    int n;
    bit ends;
    if (reset) begin
      owner = -1; last = 7; done_xfers = 0;
      m_f = 0; m_fv = 0; m_s = 0;
      return;
    end
    if (owner < 0) begin
      m_fv = 0;
      if (en && req != 0) begin
        owner = next_owner(last, req);
        last = owner; m_s = owner; done_xfers = 0;
      end
      return;
    end
    m_fv = req[owner];
    if (m_fv) begin
      m_f = w[owner];
      done_xfers++;
    end
    ends = !req[owner] || done_xfers >= MAX_HOLD || !en;
    if (!ends) return;
    n = (en && req != 0) ? next_owner(last, req) : -1;
    owner = n;
    done_xfers = 0;
    if (n >= 0) begin
      last = n; m_s = n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); req = 8'($urandom); w = 8'($urandom);
      step();
      checks++;
      if ({gnt, s, f, f_valid, busy} !== 15'd0) begin
        failures++;
        $display("FAIL reset got=%h want=0", {gnt, s, f, f_valid, busy});
      end
    end
    reset = 0;
  endtask

  task automatic test_single();
    en = 1; req = 8'h08; w = 8'h08;
    step();
    checks++;
    if (gnt !== 8'h08 || s !== 3'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant gnt=%h s=%0d want 08/3", gnt, s);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (f_valid !== 1'b1 || f !== 1'b1 || gnt !== 8'h08) begin
        failures++;
        $display("FAIL single_stream c%0d fv=%b f=%b gnt=%h want 1/1/08",
                 i, f_valid, f, gnt);
      end
    end
  endtask

  task automatic test_all();
    reset = 1; step(); reset = 0;
    en = 1; req = 8'hFF; w = 8'hAA;
    for (int k = 0; k < 36; k++) begin
      step();
      checks++;
      if (s !== 3'((k / MAX_HOLD) % 8)) begin
        failures++;
        $display("FAIL rr_seq c%0d s=%0d want %0d", k, s, (k / MAX_HOLD) % 8);
      end
      if (k > 0) begin
        checks++;
        if (f_valid !== 1'b1 || f !== 1'(((k - 1) / MAX_HOLD) % 2)) begin
          failures++;
          $display("FAIL rr_data c%0d f=%b fv=%b want %0d/1", k, f, f_valid,
                   ((k - 1) / MAX_HOLD) % 2);
        end
      end
    end
  endtask

  task automatic test_drop();
    int ones;
    ones = 0;
    reset = 1; step(); reset = 0;
    en = 1; req = 8'h24; w = 8'h04;
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      if (f_valid && f) ones++;
    end
    req = 8'h20;
    step();
    checks++;
    if (f_valid !== 1'b0 || gnt !== 8'h20) begin
      failures++;
      $display("FAIL drop_handoff fv=%b gnt=%h want 0/20", f_valid, gnt);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (f_valid && f) ones++;
      checks++;
      if (f_valid !== 1'b1 || f !== 1'b0) begin
        failures++;
        $display("FAIL drop_next c%0d fv=%b f=%b want 1/0", i, f_valid, f);
      end
    end
    checks++;
    if (ones != 2) begin
      failures++;
      $display("FAIL drop_count got=%0d want 2", ones);
    end
  endtask

  task automatic test_en_drop();
    reset = 1; step(); reset = 0;
    en = 1; req = 8'h02; w = 8'h02;
    step();
    step();
    en = 0;
    step();
    checks++;
    if (f_valid !== 1'b1 || f !== 1'b1 || gnt !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL en_drop fv=%b f=%b gnt=%h busy=%b want 1/1/00/0",
               f_valid, f, gnt, busy);
    end
    w = 8'h00;
    step();
    checks++;
    if (f_valid !== 1'b0 || f !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_after fv=%b f=%b busy=%b want 0/1/0",
               f_valid, f, busy);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1; step(); reset = 0;
    en = 1; req = 8'h40; w = 8'h40;
    step();
    step();
    reset = 1;
    step();
    checks++;
    if ({gnt, s, f, f_valid, busy} !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h want 0", {gnt, s, f, f_valid, busy});
    end
    reset = 0;
    step();
    checks++;
    if (gnt !== 8'h40 || s !== 3'd6) begin
      failures++;
      $display("FAIL reset_regrant gnt=%h s=%0d want 40/6", gnt, s);
    end
  endtask

  task automatic test_random();
    logic [14:0] ev;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: req = 8'h01 << $urandom_range(0, 7);
        1: req = 8'h00;
        default: req = 8'($urandom);
      endcase
      w = 8'($urandom);
      step();
      ev = expect_vec();
      checks++;
      if ({gnt, s, f, f_valid, busy} !== ev) begin
        failures++;
        $display("FAIL random c%0d got=%h want=%h", i,
                 {gnt, s, f, f_valid, busy}, ev);
      end
      checks++;
      if ((gnt & (gnt - 8'h01)) != 0 || (busy && !gnt[s])) begin
        failures++;
        $display("FAIL onehot c%0d gnt=%h s=%0d busy=%b", i, gnt, s, busy);
      end
    end
    reset = 0;
  endtask

  initial begin
    owner = -1; last = 7; done_xfers = 0;
    m_f = 0; m_fv = 0; m_s = 0;
    reset = 1; en = 0; req = 0; w = 0;
    test_reset();
    test_single();
    test_all();
    test_drop();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
